// File: rtl/scalar_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scalar_regfile_pkg
// Description : Shared types and default constants for the scalar register
//               file. Holds the write-operation encoding and the default
//               parameter values used by the top and the ALU.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package scalar_regfile_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_NUM_SCALARS = 8;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_NUM_RD      = 2;

    typedef enum logic [1:0] {
        OP_SET     = 2'b00,
        OP_ADD     = 2'b01,
        OP_CLR     = 2'b10,
        OP_ILLEGAL = 2'b11
    } wr_op_e;

endpackage : scalar_regfile_pkg
`default_nettype wire

// File: rtl/scalar_regfile_alu.sv
`default_nettype none
// ============================================================================
// Module      : scalar_regfile_alu
// Description : Combinational next-value unit for one register write.
//               SET passes the operand, ADD is an unsigned saturating add,
//               CLR yields zero, the illegal code leaves the value unchanged.
// Ports       : op_i      - write operation (wr_op_e encoding)
//               old_i     - current register contents
//               operand_i - write operand
//               result_o  - value to store
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_regfile_alu
    import scalar_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] old_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] result_o
);

    // One extra bit holds the carry used to detect saturation.
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum    = {1'b0, old_i} + {1'b0, operand_i};
        result_o = old_i;
        case (wr_op_e'(op_i))
            OP_SET:  result_o = operand_i;
            OP_ADD:  result_o = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            OP_CLR:  result_o = '0;
            default: result_o = old_i;
        endcase
    end

endmodule : scalar_regfile_alu
`default_nettype wire

// File: rtl/scalar_regfile.sv
`default_nettype none
// ============================================================================
// Module      : scalar_regfile
// Description : Scalar register file with per-register busy (reservation)
//               bits, SET/ADD/CLR writes, NUM_RD registered read ports with
//               write-to-read bypass, and a sticky error flag.
// Ports       : clk, rst                    - clock, async active-high reset
//               rd_en_i/rd_addr_i           - per-port read request/address
//               rd_data_o/rd_valid_o        - registered read data/valid
//               we_i/wr_addr_i/wr_op_i/wr_data_i - write request
//               resv_en_i/resv_addr_i       - mark a register busy
//               registers_out_o/busy_out_o  - live register and busy state
//               err_o/err_clr_i             - sticky error flag and clear
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_regfile
    import scalar_regfile_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_SCALARS = DEF_NUM_SCALARS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_RD      = DEF_NUM_RD
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD-1:0]                 rd_en_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]     rd_addr_i,
    output logic [NUM_RD-1:0][WIDTH-1:0]      rd_data_o,
    output logic [NUM_RD-1:0]                 rd_valid_o,
    input  logic                              we_i,
    input  logic [ADDR_W-1:0]                 wr_addr_i,
    input  logic [1:0]                        wr_op_i,
    input  logic [WIDTH-1:0]                  wr_data_i,
    input  logic                              resv_en_i,
    input  logic [ADDR_W-1:0]                 resv_addr_i,
    output logic [NUM_SCALARS-1:0][WIDTH-1:0] registers_out_o,
    output logic [NUM_SCALARS-1:0]            busy_out_o,
    output logic                              err_o,
    input  logic                              err_clr_i
);

    // One extra bit so NUM_SCALARS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_NUM_SCALARS_EXT = (ADDR_W+1)'(NUM_SCALARS);

    logic [NUM_SCALARS-1:0][WIDTH-1:0] r_regs_q, w_regs_d;
    logic [NUM_SCALARS-1:0]            r_busy_q, w_busy_d;
    logic [NUM_RD-1:0][WIDTH-1:0]      r_rd_data_q, w_rd_data_d;
    logic [NUM_RD-1:0]                 r_rd_valid_q, w_rd_valid_d, w_rd_oor;
    logic                              r_err_q, w_err_d;

    logic             w_wr_in_range, w_wr_legal, w_wr_ok;
    logic             w_resv_in_range, w_resv_ok, w_any_err;
    logic [WIDTH-1:0] w_wr_old, w_alu_result;

    assign w_wr_in_range   = {1'b0, wr_addr_i} < c_NUM_SCALARS_EXT;
    assign w_resv_in_range = {1'b0, resv_addr_i} < c_NUM_SCALARS_EXT;
    assign w_wr_legal      = (wr_op_i != OP_ILLEGAL);
    assign w_wr_ok         = we_i & w_wr_in_range & w_wr_legal;
    assign w_resv_ok       = resv_en_i & w_resv_in_range;

    // Mux by compare rather than direct indexing so an out-of-range
    // address never indexes past the implemented registers.
    always_comb begin
        w_wr_old = '0;
        for (int i = 0; i < NUM_SCALARS; i++) begin
            if (wr_addr_i == ADDR_W'(i)) begin
                w_wr_old = r_regs_q[i];
            end
        end
    end

    scalar_regfile_alu #(
        .WIDTH     (WIDTH)
    ) u_alu (
        .op_i      (wr_op_i),
        .old_i     (w_wr_old),
        .operand_i (wr_data_i),
        .result_o  (w_alu_result)
    );

    generate
        for (genvar gi = 0; gi < NUM_SCALARS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);
            logic w_wr_hit;
            logic w_resv_hit;

            assign w_wr_hit       = w_wr_ok & (wr_addr_i == c_IDX);
            assign w_resv_hit     = w_resv_ok & (resv_addr_i == c_IDX);
            assign w_regs_d[gi]   = w_wr_hit ? w_alu_result : r_regs_q[gi];
            // A reservation outranks the clear caused by a same-edge write.
            assign w_busy_d[gi]   = w_resv_hit | (r_busy_q[gi] & ~w_wr_hit);
        end

        for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rd
            logic             w_in_range;
            logic [WIDTH-1:0] w_sel_data;
            logic             w_sel_busy;

            assign w_in_range = {1'b0, rd_addr_i[gp]} < c_NUM_SCALARS_EXT;

            // Select from post-update state so a same-edge write is visible.
            always_comb begin
                w_sel_data = '0;
                w_sel_busy = 1'b0;
                for (int i = 0; i < NUM_SCALARS; i++) begin
                    if (rd_addr_i[gp] == ADDR_W'(i)) begin
                        w_sel_data = w_regs_d[i];
                        w_sel_busy = w_busy_d[i];
                    end
                end
            end

            assign w_rd_oor[gp]     = rd_en_i[gp] & ~w_in_range;
            assign w_rd_valid_d[gp] = rd_en_i[gp] & w_in_range & ~w_sel_busy;
            assign w_rd_data_d[gp]  = rd_en_i[gp] ? (w_in_range ? w_sel_data : '0)
                                                  : r_rd_data_q[gp];
        end
    endgenerate

    assign w_any_err = (we_i & ~(w_wr_in_range & w_wr_legal))
                     | (resv_en_i & ~w_resv_in_range)
                     | (|w_rd_oor);
    // A new error outranks a simultaneous clear.
    assign w_err_d   = w_any_err | (r_err_q & ~err_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs_q     <= '0;
            r_busy_q     <= '0;
            r_rd_data_q  <= '0;
            r_rd_valid_q <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_regs_q     <= w_regs_d;
            r_busy_q     <= w_busy_d;
            r_rd_data_q  <= w_rd_data_d;
            r_rd_valid_q <= w_rd_valid_d;
            r_err_q      <= w_err_d;
        end
    end

    assign rd_data_o       = r_rd_data_q;
    assign rd_valid_o      = r_rd_valid_q;
    assign registers_out_o = r_regs_q;
    assign busy_out_o      = r_busy_q;
    assign err_o           = r_err_q;

endmodule : scalar_regfile
`default_nettype wire

// File: tb/tb_scalar_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_regfile
// Description : Directed self-checking bench for scalar_regfile with default
//               parameters (16-bit, 8 registers, 4-bit addresses, 2 ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_regfile;

    localparam logic [1:0] c_SET = 2'b00;
    localparam logic [1:0] c_ADD = 2'b01;
    localparam logic [1:0] c_CLR = 2'b10;
    localparam logic [1:0] c_ILL = 2'b11;

    logic              clk;
    logic              rst;
    logic [1:0]        rd_en;
    logic [1:0][3:0]   rd_addr;
    logic [1:0][15:0]  rd_data;
    logic [1:0]        rd_valid;
    logic              we;
    logic [3:0]        wr_addr;
    logic [1:0]        wr_op;
    logic [15:0]       wr_data;
    logic              resv_en;
    logic [3:0]        resv_addr;
    logic [7:0][15:0]  registers_out;
    logic [7:0]        busy_out;
    logic              err;
    logic              err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [8];

    scalar_regfile #(
        .WIDTH           (16),
        .NUM_SCALARS     (8),
        .ADDR_W          (4),
        .NUM_RD          (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en_i         (rd_en),
        .rd_addr_i       (rd_addr),
        .rd_data_o       (rd_data),
        .rd_valid_o      (rd_valid),
        .we_i            (we),
        .wr_addr_i       (wr_addr),
        .wr_op_i         (wr_op),
        .wr_data_i       (wr_data),
        .resv_en_i       (resv_en),
        .resv_addr_i     (resv_addr),
        .registers_out_o (registers_out),
        .busy_out_o      (busy_out),
        .err_o           (err),
        .err_clr_i       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_model();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_regs[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] op, input logic [15:0] d);
        we = 1'b1; wr_addr = a; wr_op = op; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v35 [4];
        v35[0] = 16'h1234; v35[1] = 16'h5678; v35[2] = 16'h9ABC; v35[3] = 16'hDEF0;

        rst = 1'b1; rd_en = '0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_op = '0;
        wr_data = '0; resv_en = 1'b0; resv_addr = '0; err_clr = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_regs",  registers_out, 128'h0);
        check_eq("reset_busy",  busy_out, 8'h00);
        check_eq("reset_valid", rd_valid, 2'b00);
        check_eq("reset_data",  rd_data, 32'h0);
        check_eq("reset_err",   err, 1'b0);
        rst = 1'b0;

        // Basic SET then pipelined reads on port 0
        for (int k = 0; k < 4; k++) begin
            wr(4'(k), c_SET, v35[k]);
            m_regs[k] = v35[k];
        end
        rd_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_addr[0] = 4'(k);
            tick();
            check_eq($sformatf("rd_data_a%0d", k), rd_data[0], v35[k]);
            check_eq($sformatf("rd_valid_a%0d", k), rd_valid[0], 1'b1);
        end
        rd_en = '0;
        tick();
        check_eq("valid_drop", rd_valid[0], 1'b0);
        check_eq("data_hold",  rd_data[0], 16'hDEF0);

        // ALU operations
        wr(4'd2, c_SET, 16'hFFF0);
        wr(4'd2, c_ADD, 16'h0020);
        check_eq("add_sat", registers_out[2], 16'hFFFF);
        wr(4'd1, c_ADD, 16'h0001);
        check_eq("add_plain", registers_out[1], 16'h5679);
        wr(4'd3, c_CLR, 16'h1111);
        check_eq("clr", registers_out[3], 16'h0000);
        m_regs[1] = 16'h5679; m_regs[2] = 16'hFFFF; m_regs[3] = 16'h0000;
        check_eq("regs_after_alu", registers_out, pack_model());

        // Write with same-cycle reads on both ports (bypass)
        we = 1'b1; wr_addr = 4'd5; wr_op = c_SET; wr_data = 16'hAAAA;
        rd_en = 2'b11; rd_addr[0] = 4'd5; rd_addr[1] = 4'd5;
        tick();
        we = 1'b0; rd_en = '0;
        m_regs[5] = 16'hAAAA;
        check_eq("bypass_p0", rd_data[0], 16'hAAAA);
        check_eq("bypass_p1", rd_data[1], 16'hAAAA);
        check_eq("bypass_valid", rd_valid, 2'b11);

        // Reservation handling
        resv_en = 1'b1; resv_addr = 4'd4; rd_en = 2'b01; rd_addr[0] = 4'd4;
        tick();
        resv_en = 1'b0; rd_en = '0;
        check_eq("resv_busy", busy_out, 8'h10);
        check_eq("resv_rd_valid", rd_valid[0], 1'b0);
        check_eq("resv_rd_data", rd_data[0], 16'h0000);
        wr(4'd4, c_SET, 16'h0042);
        m_regs[4] = 16'h0042;
        check_eq("wr_clears_busy", busy_out, 8'h00);
        rd_en = 2'b01; rd_addr[0] = 4'd4;
        tick();
        rd_en = '0;
        check_eq("rd_after_clear", rd_data[0], 16'h0042);
        check_eq("rd_after_clear_v", rd_valid[0], 1'b1);
        resv_en = 1'b1; resv_addr = 4'd4;
        we = 1'b1; wr_addr = 4'd4; wr_op = c_SET; wr_data = 16'h0077;
        tick();
        resv_en = 1'b0; we = 1'b0;
        m_regs[4] = 16'h0077;
        check_eq("resv_wins_busy", busy_out, 8'h10);
        check_eq("resv_wins_data", registers_out[4], 16'h0077);

        // Error handling
        wr(4'd9, c_SET, 16'hFFFF);
        check_eq("oor_wr_noeffect", registers_out, pack_model());
        check_eq("oor_wr_err", err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("err_cleared", err, 1'b0);
        err_clr = 1'b1;
        we = 1'b1; wr_addr = 4'd0; wr_op = c_ILL; wr_data = 16'h5555;
        tick();
        err_clr = 1'b0; we = 1'b0;
        check_eq("illegal_beats_clr", err, 1'b1);
        check_eq("illegal_noeffect", registers_out, pack_model());
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("err_cleared2", err, 1'b0);
        resv_en = 1'b1; resv_addr = 4'd15;
        tick();
        resv_en = 1'b0;
        check_eq("oor_resv_err", err, 1'b1);
        check_eq("oor_resv_busy", busy_out, 8'h10);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_en = 2'b10; rd_addr[1] = 4'd12;
        tick();
        rd_en = '0;
        check_eq("oor_rd_err", err, 1'b1);
        check_eq("oor_rd_valid", rd_valid[1], 1'b0);
        check_eq("oor_rd_data", rd_data[1], 16'h0000);

        // Asynchronous reset mid-sequence
        rd_en = 2'b01; rd_addr[0] = 4'd0;
        tick();
        check_eq("pre_rst_valid", rd_valid[0], 1'b1);
        we = 1'b1; wr_addr = 4'd0; wr_op = c_SET; wr_data = 16'hBEEF; rd_en = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_regs",  registers_out, 128'h0);
        check_eq("arst_busy",  busy_out, 8'h00);
        check_eq("arst_data",  rd_data, 32'h0);
        check_eq("arst_valid", rd_valid, 2'b00);
        check_eq("arst_err",   err, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0; we = 1'b0; rd_en = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        tick();
        check_eq("rst_discards_op", registers_out, pack_model());

        wr(4'd7, c_SET, 16'h1357);
        check_eq("post_rst_wr", registers_out[7], 16'h1357);
        rd_en = 2'b10; rd_addr[1] = 4'd7;
        tick();
        rd_en = '0;
        check_eq("post_rst_rd", rd_data[1], 16'h1357);
        check_eq("post_rst_rd_v", rd_valid[1], 1'b1);
        wr(4'd6, c_ADD, 16'hFFFF);
        check_eq("add_exact_max", registers_out[6], 16'hFFFF);
        wr(4'd6, c_ADD, 16'h0001);
        check_eq("add_sat_max", registers_out[6], 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scalar_regfile
`default_nettype wire

// File: doc/scalar_regfile.md
SCALAR_REGFILE -- requirements
Module: scalar_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each scalar.
REQ-002 SHALL have parameter NUM_SCALARS, default 8, number of implemented registers (2..2**ADDR_W).
REQ-003 SHALL have parameter ADDR_W, default 4, address width of all address ports.
REQ-004 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_en  input  [NUM_RD]  per-port read request.
REQ-008 rd_addr  input  [NUM_RD][ADDR_W]  per-port read address.
REQ-009 rd_data  output  [NUM_RD][WIDTH]  registered read data.
REQ-010 rd_valid  output  [NUM_RD]  read data valid and not reserved.
REQ-011 we  input  1  write strobe.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_op  input  2  00 SET, 01 ADD, 10 CLR, 11 illegal.
REQ-014 wr_data  input  WIDTH  write operand.
REQ-015 resv_en / resv_addr  input  1 / ADDR_W  mark a register busy (pending producer).
REQ-016 registers_out  output  [NUM_SCALARS][WIDTH]  live register contents.
REQ-017 busy_out  output  [NUM_SCALARS]  live busy bits.
REQ-018 err  output  1  sticky error flag; err_clr  input  1  clears it.

Function
REQ-019 Address >= NUM_SCALARS SHALL be out of range on any port.
REQ-020 we with in-range address SHALL update that register at the clock edge: SET -> wr_data; ADD -> unsigned saturating old+wr_data (clamp to 2**WIDTH-1); CLR -> 0.
REQ-021 Any in-range write SHALL clear the busy bit of its address in the same edge.
REQ-022 resv_en with in-range address SHALL set that busy bit; with a simultaneous write to the same address, reserve SHALL win (busy ends 1, data still updated).
REQ-023 Reads SHALL have 1-cycle latency: rd_data/rd_valid at edge N+1 reflect state after the edge-N update (write-to-read bypass, no stale data).
REQ-024 rd_valid[p] SHALL be rd_en[p] AND in-range AND post-update busy bit 0; rd_data[p] SHALL carry stored value whenever in range, else 0.
REQ-025 rd_valid SHALL deassert one cycle after rd_en deasserts; rd_data SHALL hold its last value while rd_en is low.
REQ-026 Multiple read ports addressing the same register SHALL return identical data.
REQ-027 err SHALL set on out-of-range write, reserve or enabled read, or wr_op 11 with we; offending writes/reserves SHALL change no state.
REQ-028 err_clr SHALL clear err; a simultaneous new error SHALL win (err stays 1).
REQ-029 registers_out and busy_out SHALL be direct register outputs (0 cycles after edge).

Reset
REQ-030 rst asserted SHALL immediately force all registers 0, busy 0, rd_data 0, rd_valid 0, err 0, independent of clk.
REQ-031 Operations presented during reset SHALL be discarded; first effective edge is the first rising clk after rst deasserts.

Structure
REQ-032 Package scalar_regfile_pkg SHALL hold the wr_op enum (OP_SET, OP_ADD, OP_CLR, OP_ILLEGAL) and default parameter constants.
REQ-033 Sub-module scalar_regfile_alu SHALL compute next value from (op, old, operand), purely combinational, with saturation.
REQ-034 Read ports SHALL be generated per NUM_RD; no per-port hand-written logic.

Verification
REQ-035 SET 0x1234,0x5678,0x9ABC,0xDEF0 to addr 0..3, then read port0 addr 0..3 -> rd_data 0x1234,0x5678,0x9ABC,0xDEF0, rd_valid 1, each one cycle after request.
REQ-036 SET addr2=0xFFF0, ADD 0x0020 -> 0xFFFF (saturated); ADD 0x0001 to addr1=0x5678 -> 0x5679; CLR addr3 -> 0.
REQ-037 Same-cycle SET addr5=0xAAAA with port0 and port1 reading addr5 -> both ports return 0xAAAA, rd_valid 1, next cycle.
REQ-038 Reserve addr4, read addr4 -> rd_valid 0, busy_out[4]=1; SET addr4=0x0042 -> busy cleared, next read 0x0042 valid; same-cycle reserve+write -> busy stays 1.
REQ-039 Write addr 9 (NUM_SCALARS=8) -> no register changes, err=1; err_clr -> err=0; err_clr with wr_op 11 same cycle -> err=1.
REQ-040 Assert rst mid-sequence between edges -> all outputs 0 before next clk edge; later writes behave normally.
